pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the MIPS fetch stage; next generation of the single-cycle PC update logic. Adds configurable address width and vectors, fetch stall, six branch-condition modes, optional one-instruction branch delay slot, and precise exception entry/return with an EPC register and a misaligned-jump-register fault. Sits between the decode/control unit and instruction memory; `pc` drives the instruction-memory address directly.

## Interface
- `AW`, 32: address width; legal range AW ≥ 28.
- `RESET_VECTOR`, 0: `pc` value after reset.
- `EXC_VECTOR`, 32'h0000_0180 (zero-extended to AW): exception entry address.
- `DELAY_SLOT`, 0: 0 = transfers take effect on the next cycle; 1 = one delay-slot instruction executes first.

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `stall` in 1: hold `pc` and all state.
- `branch` in 1, `branch_op` in 3: conditional branch and its condition code.
- `zero`, `negative` in 1: ALU flags for the current instruction.
- `jump` in 1, `jea` in 26: J-type jump and its target field.
- `jump_register` in 1, `rs_data` in AW: JR and its target.
- `imm_sign_extend` in AW: branch offset in words.
- `exception` in 1, `eret` in 1: trap request; return from exception.
- `pc` out AW: current fetch address.
- `epc` out AW: saved exception PC.
- `redirect` out 1: high in the cycle `pc` holds a non-sequential value.
- `misaligned_fault` out 1: high for one cycle when a JR target with `rs_data[1:0] != 0` was converted to an exception.

## Operation
- `pc4 = pc + 4`, modulo 2^AW. `jaddr = {pc4[AW-1:28], jea, 2'b00}`. `baddr = pc4 + (imm_sign_extend << 2)`, truncated to AW.
- Branch taken = `branch` AND condition:
  - BEQ(0): `zero`
  - BNE(1): `!zero`
  - BLEZ(2): `zero | negative`
  - BGTZ(3): `!zero & !negative`
  - BLTZ(4): `negative`
  - BGEZ(5): `!negative`
  - 6 and 7: never taken.
- Priority, highest first:
  - `exception`, or JR with a misaligned target: `epc <= pc`, `pc <= EXC_VECTOR`, pending transfer cleared.
  - `eret`: `pc <= epc`.
  - `jump`: `jaddr`.
  - Branch taken: `baddr`.
  - `jump_register` (aligned): `rs_data`.
  - Otherwise: `pc4`.
- States: SEQ, SLOT. SLOT is reachable only when DELAY_SLOT=1.
  - DELAY_SLOT=1, SEQ, jump/branch-taken/aligned JR: latch target into `target_q`, `pc <= pc4`, go to SLOT.
  - SLOT: `pc <= target_q`, `redirect` asserts, return to SEQ. Transfer requests arriving in SLOT are ignored.
  - Exception and `eret` are never delayed; in SLOT they override and drop `target_q`.
- `stall`: `pc`, `epc`, state and `target_q` hold. `redirect` and `misaligned_fault` deassert. `exception` overrides `stall`; `eret` does not.

## Timing
- Reset values: `pc` = RESET_VECTOR, `epc` = 0, `redirect` = 0, `misaligned_fault` = 0, state = SEQ, `target_q` = 0.
- Latency:
  - DELAY_SLOT=0: inputs in cycle n determine `pc` in cycle n+1.
  - DELAY_SLOT=1: the target appears in cycle n+2, with `pc4` in n+1.
- `redirect` and `misaligned_fault` are registered and aligned with the new `pc`. `redirect` also asserts for exception entry and `eret`.
- Wrap-around: `pc = 2^AW-4` with no transfer gives `pc = 0`, `redirect` = 0.
- `rst_n` low mid-SLOT: the pending target is discarded. Reset wins over `exception`.
- `exception` and `eret` in the same cycle: exception wins, and `epc` takes the current `pc`.

## Structure
- Package `pc_pkg`: `branch_op_e` enum (BEQ..BGEZ, 3 bits) and `pc_state_e` enum (SEQ, SLOT).
- Sub-module `branch_cond`: combinational; inputs `branch_op`, `zero`, `negative`; output `taken`. Reused by the pipeline hazard unit.

## Test plan
- Reset then 3 idle cycles: `pc` = 0, 4, 8, 12; `redirect` = 0 throughout.
- DELAY_SLOT=0, `pc` = 0x100, BNE with `zero` = 0 and imm = 3: next `pc` = 0x110, `redirect` = 1; repeat with `zero` = 1: `pc` = 0x104.
- DELAY_SLOT=1, `pc` = 0x200, `jump`, `jea` = 0x40: `pc` sequence 0x204 then 0x100; a `branch` in the slot cycle is ignored.
- `jump_register` with `rs_data` = 0x1002 at `pc` = 0x300: `pc` = EXC_VECTOR, `epc` = 0x300, `misaligned_fault` = 1 for one cycle; then `eret`: `pc` = 0x300.
- `stall` held 3 cycles at `pc` = 0x40: `pc` stays 0x40; `exception` during the stall: `pc` = EXC_VECTOR next cycle, `epc` = 0x40.
- Simultaneous `jump` and taken BEQ: the `jaddr` result wins; `pc` = 2^32-4 idle: `pc` wraps to 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program-counter sequencer.
package pc_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'd0,
        BNE  = 3'd1,
        BLEZ = 3'd2,
        BGTZ = 3'd3,
        BLTZ = 3'd4,
        BGEZ = 3'd5
    } branch_op_e;

    typedef enum logic {
        SEQ  = 1'b0,
        SLOT = 1'b1
    } pc_state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from ALU flags; codes 6 and 7 are never taken.
module branch_cond
    import pc_pkg::*;
(
    input  logic [2:0] branch_op,
    input  logic       zero,
    input  logic       negative,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (branch_op)
            BEQ:     taken = zero;
            BNE:     taken = ~zero;
            BLEZ:    taken = zero | negative;
            BGTZ:    taken = ~zero & ~negative;
            BLTZ:    taken = negative;
            BGEZ:    taken = ~negative;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: jumps, conditional branches, JR, optional delay slot,
// exception entry with EPC and eret.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     AW           = 32,
    parameter logic [AW-1:0]   RESET_VECTOR = '0,
    parameter logic [AW-1:0]   EXC_VECTOR   = AW'(32'h0000_0180),
    parameter bit              DELAY_SLOT   = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          branch,
    input  logic [2:0]    branch_op,
    input  logic          zero,
    input  logic          negative,
    input  logic          jump,
    input  logic [25:0]   jea,
    input  logic          jump_register,
    input  logic [AW-1:0] rs_data,
    input  logic [AW-1:0] imm_sign_extend,
    input  logic          exception,
    input  logic          eret,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] epc,
    output logic          redirect,
    output logic          misaligned_fault
);

    pc_state_e     state;
    logic [AW-1:0] target_q;
    logic [AW-1:0] pc4;
    logic [AW-1:0] jaddr;
    logic [AW-1:0] baddr;
    logic [AW-1:0] xfer_target;
    logic          cond_taken;
    logic          br_taken;
    logic          jr_misaligned;
    logic          trap;
    logic          xfer;

    branch_cond u_branch_cond (
        .branch_op (branch_op),
        .zero      (zero),
        .negative  (negative),
        .taken     (cond_taken)
    );

    assign pc4      = pc + AW'(4);
    assign baddr    = pc4 + (imm_sign_extend << 2);
    assign br_taken = branch & cond_taken;

    always_comb begin
        jaddr       = pc4;
        jaddr[27:0] = {jea, 2'b00};
    end

    // A JR arriving in the delay slot is ignored, so it cannot fault either.
    assign jr_misaligned = jump_register & (rs_data[1:0] != 2'b00) & (state == SEQ);
    assign trap          = exception | (~stall & jr_misaligned);
    assign xfer          = jump | br_taken | jump_register;

    always_comb begin
        if (jump)
            xfer_target = jaddr;
        else if (br_taken)
            xfer_target = baddr;
        else
            xfer_target = rs_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc               <= RESET_VECTOR;
            epc              <= '0;
            redirect         <= 1'b0;
            misaligned_fault <= 1'b0;
            state            <= SEQ;
            target_q         <= '0;
        end else begin
            misaligned_fault <= 1'b0;
            if (trap) begin
                epc              <= pc;
                pc               <= EXC_VECTOR;
                redirect         <= 1'b1;
                misaligned_fault <= ~exception;
                state            <= SEQ;
                target_q         <= '0;
            end else if (stall) begin
                redirect <= 1'b0;
            end else if (eret) begin
                pc       <= epc;
                redirect <= 1'b1;
                state    <= SEQ;
                target_q <= '0;
            end else if (state == SLOT) begin
                pc       <= target_q;
                redirect <= 1'b1;
                state    <= SEQ;
            end else if (xfer && DELAY_SLOT) begin
                target_q <= xfer_target;
                pc       <= pc4;
                redirect <= 1'b0;
                state    <= SLOT;
            end else if (xfer) begin
                pc       <= xfer_target;
                redirect <= 1'b1;
            end else begin
                pc       <= pc4;
                redirect <= 1'b0;
            end
        end
    end

endmodule
